// File: rtl/swipt_bridge_gen.sv
// Parametrised SWIPT half-bridge gate generator.
// NLEG complementary gate pairs share one period counter. Each leg is shifted
// by a multiple of the phase step. Configuration is double-buffered and takes
// effect only at period boundaries.
module swipt_bridge_gen #(
  parameter int unsigned NLEG       = 2,
  parameter int unsigned PER_W      = 16,
  parameter int unsigned DT_W       = 8,
  parameter int unsigned DEF_PERIOD = 2500,
  parameter int unsigned DEF_ON     = 1250,
  parameter int unsigned DEF_DEAD   = 10,
  parameter int unsigned DEF_PHASE  = 1250
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [PER_W-1:0] cfg_period,
  input  logic [PER_W-1:0] cfg_on,
  input  logic [DT_W-1:0]  cfg_dead,
  input  logic [PER_W-1:0] cfg_phase,
  output logic [NLEG-1:0]  gate_hi,
  output logic [NLEG-1:0]  gate_lo,
  output logic             period_start,
  output logic             active,
  output logic             cfg_err
);

  localparam int unsigned XW = PER_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_n;
  logic [PER_W-1:0] cnt_q, cnt_n;

  // active configuration
  logic [PER_W-1:0] per_q, on_q, ph_q;
  logic [DT_W-1:0]  dead_q;
  // pending shadow configuration
  logic [PER_W-1:0] per_p, on_p, ph_p;
  logic [DT_W-1:0]  dead_p;
  logic             pend_v;
  // configuration for the next cycle
  logic [PER_W-1:0] per_n, on_n, ph_n;
  logic [DT_W-1:0]  dead_n;

  logic [PER_W-1:0] off_q [NLEG];
  logic [PER_W-1:0] off_n [NLEG];

  logic             cfg_ok, wrap, apply;
  logic [NLEG-1:0]  win_hi, win_lo;
  logic [XW-1:0]    acc, sum;
  logic [XW-1:0]    cnt_x, off_x, per_x, on_x, dead_x, pos;

  function automatic logic [PER_W-1:0] def_off(input int unsigned k);
    return PER_W'((k * DEF_PHASE) % DEF_PERIOD);
  endfunction

  // Validity of the requested configuration, all compares at PER_W+1 bits.
  always_comb begin
    cfg_ok = (XW'(cfg_period) >= XW'(4))
          && (XW'(cfg_dead) < XW'(cfg_on))
          && ((XW'(cfg_on) + XW'(cfg_dead)) < XW'(cfg_period))
          && (XW'(cfg_phase) < XW'(cfg_period));
  end

  // Period boundary detection, pending apply and next counter/state.
  always_comb begin
    wrap    = (cnt_q == per_q - PER_W'(1));
    apply   = pend_v && ((state_q == S_IDLE) || wrap);
    per_n   = apply ? per_p  : per_q;
    on_n    = apply ? on_p   : on_q;
    dead_n  = apply ? dead_p : dead_q;
    ph_n    = apply ? ph_p   : ph_q;
    state_n = state_q;
    cnt_n   = '0;
    if (state_q == S_IDLE) begin
      if (enable) state_n = S_RUN;
    end else begin
      if (!enable)   state_n = S_IDLE;
      else if (!wrap) cnt_n = cnt_q + PER_W'(1);
    end
  end

  // Leg offsets from the configuration that will be active next cycle, so the
  // offset registers switch on the same edge as the configuration itself.
  always_comb begin
    acc = '0;
    sum = '0;
    for (int unsigned k = 0; k < NLEG; k++) begin
      off_n[k] = acc[PER_W-1:0];
      sum      = acc + XW'(ph_n);
      acc      = (sum >= XW'(per_n)) ? (sum - XW'(per_n)) : sum;
    end
  end

  // Per-leg position inside the period and the resulting gate windows.
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    cnt_x  = XW'(cnt_q);
    per_x  = XW'(per_q);
    on_x   = XW'(on_q);
    dead_x = XW'(dead_q);
    off_x  = '0;
    pos    = '0;
    for (int unsigned k = 0; k < NLEG; k++) begin
      off_x     = XW'(off_q[k]);
      pos       = (cnt_x >= off_x) ? (cnt_x - off_x) : (cnt_x + per_x - off_x);
      win_hi[k] = (pos >= dead_x) && (pos < on_x);
      win_lo[k] = (pos >= on_x + dead_x) && (pos < per_x);
    end
  end

  // State, counter, configuration buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      per_q        <= PER_W'(DEF_PERIOD);
      on_q         <= PER_W'(DEF_ON);
      dead_q       <= DT_W'(DEF_DEAD);
      ph_q         <= PER_W'(DEF_PHASE);
      per_p        <= PER_W'(DEF_PERIOD);
      on_p         <= PER_W'(DEF_ON);
      dead_p       <= DT_W'(DEF_DEAD);
      ph_p         <= PER_W'(DEF_PHASE);
      pend_v       <= 1'b0;
      for (int unsigned k = 0; k < NLEG; k++) off_q[k] <= def_off(k);
      gate_hi      <= '0;
      gate_lo      <= '0;
      period_start <= 1'b0;
      active       <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      per_q   <= per_n;
      on_q    <= on_n;
      dead_q  <= dead_n;
      ph_q    <= ph_n;
      off_q   <= off_n;
      // An apply consumes the old shadow; a load in the same cycle refills it.
      pend_v  <= pend_v && !apply;
      if (load) begin
        if (cfg_ok) begin
          per_p   <= cfg_period;
          on_p    <= cfg_on;
          dead_p  <= cfg_dead;
          ph_p    <= cfg_phase;
          pend_v  <= 1'b1;
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      gate_hi      <= (state_q == S_RUN && enable) ? win_hi : '0;
      gate_lo      <= (state_q == S_RUN && enable) ? win_lo : '0;
      period_start <= (state_n == S_RUN) && (cnt_n == '0);
      active       <= (state_n == S_RUN);
    end
  end

  // High and low side of a leg must never conduct together.
  assert property (@(posedge clk) (gate_hi & gate_lo) == '0);

endmodule

// File: tb/tb_swipt_bridge_gen.sv
// Self-checking bench for swipt_bridge_gen (4 legs), with a cycle-level
// behavioural model using modulo arithmetic for the leg positions.
module tb_swipt_bridge_gen;
  localparam int NL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, load;
  logic [15:0]   cfg_period, cfg_on, cfg_phase;
  logic [7:0]    cfg_dead;
  logic [NL-1:0] gate_hi, gate_lo;
  logic          period_start, active, cfg_err;

  int checks   = 0;
  int failures = 0;

  swipt_bridge_gen #(.NLEG(NL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .cfg_period(cfg_period), .cfg_on(cfg_on), .cfg_dead(cfg_dead),
    .cfg_phase(cfg_phase), .gate_hi(gate_hi), .gate_lo(gate_lo),
    .period_start(period_start), .active(active), .cfg_err(cfg_err)
  );

  // model state
  bit            started = 1'b0;
  bit            m_run, q_v, m_err;
  int            m_cnt, m_per, m_on, m_dead, m_ph;
  int            q_per, q_on, q_dead, q_ph;
  logic [NL-1:0] e_hi, e_lo;
  bit            e_ps, e_act;

  task automatic model_step();
    int pos;
    bit wrap, take;
    if (rst) begin
      m_run = 0; m_cnt = 0; q_v = 0; m_err = 0;
      m_per = 2500; m_on = 1250; m_dead = 10; m_ph = 1250;
      e_hi = '0; e_lo = '0; e_ps = 0; e_act = 0;
    end else begin
      e_hi = '0; e_lo = '0;
      if (m_run && enable) begin
        for (int k = 0; k < NL; k++) begin
          pos = (m_cnt + m_per - (k * m_ph) % m_per) % m_per;
          e_hi[k] = (pos >= m_dead) && (pos < m_on);
          e_lo[k] = (pos >= m_on + m_dead);
        end
      end
      wrap = m_run && (m_cnt == m_per - 1);
      take = q_v && (!m_run || wrap);
      if (take) begin
        m_per = q_per; m_on = q_on; m_dead = q_dead; m_ph = q_ph; q_v = 0;
      end
      if (load) begin
        if (int'(cfg_period) >= 4 && int'(cfg_dead) < int'(cfg_on) &&
            int'(cfg_on) + int'(cfg_dead) < int'(cfg_period) &&
            int'(cfg_phase) < int'(cfg_period)) begin
          q_per = cfg_period; q_on = cfg_on; q_dead = cfg_dead; q_ph = cfg_phase;
          q_v = 1; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
      if (m_run) begin
        if (enable) m_cnt = wrap ? 0 : m_cnt + 1;
        else begin m_run = 0; m_cnt = 0; end
      end else if (enable) begin
        m_run = 1; m_cnt = 0;
      end
      e_ps  = m_run && (m_cnt == 0);
      e_act = m_run;
    end
    started = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (started) begin
      checks++;
      if (gate_hi !== e_hi || gate_lo !== e_lo || period_start !== e_ps ||
          active !== e_act || cfg_err !== m_err) begin
        failures++;
        $display("FAIL model_cmp t=%0t got hi=%b lo=%b ps=%b act=%b err=%b exp hi=%b lo=%b ps=%b act=%b err=%b",
                 $time, gate_hi, gate_lo, period_start, active, cfg_err,
                 e_hi, e_lo, e_ps, e_act, m_err);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int p, input int o, input int d, input int ph);
    cfg_period = 16'(p); cfg_on = 16'(o); cfg_dead = 8'(d); cfg_phase = 16'(ph);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_ps(input string nm);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (period_start) return;
    end
    chk(nm, 0, 1);
  endtask

  task automatic count_ps(output int n);
    n = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      n++;
      if (period_start) return;
    end
    n = -1;
  endtask

  task automatic run_until_cnt(input int target);
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (m_cnt == target) return;
    end
    chk("run_until_cnt_timeout", m_cnt, target);
  endtask

  int n;
  int bad_tab [7][5] = '{
    '{3,    2,   0,  0,   1},
    '{100,  50,  50, 0,   1},
    '{100,  60,  40, 0,   1},
    '{100,  60,  39, 100, 1},
    '{100,  60,  39, 99,  0},
    '{4,    2,   1,  3,   0},
    '{2000, 800, 5,  500, 0}
  };

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    cfg_period = '0; cfg_on = '0; cfg_dead = '0; cfg_phase = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_hi", int'(gate_hi), 0);
    chk("reset_lo", int'(gate_lo), 0);
    chk("reset_ps", int'(period_start), 0);
    chk("reset_act", int'(active), 0);
    chk("reset_err", int'(cfg_err), 0);
    rst = 1'b0;
    tick();
    enable = 1'b1;

    // defaults: period 2500, on 1250, dead 10, phase 1250
    wait_ps("first_ps");
    repeat (10) @(negedge clk);
    chk("def_c9_hi", int'(gate_hi), 0);
    chk("def_c9_lo", int'(gate_lo), 0);
    @(negedge clk);
    chk("def_c10_hi", int'(gate_hi), 'b0101);
    chk("def_c10_lo", int'(gate_lo), 'b1010);
    repeat (1240) @(negedge clk);
    chk("def_c1250_hi", int'(gate_hi), 0);
    chk("def_c1250_lo", int'(gate_lo), 0);
    repeat (10) @(negedge clk);
    chk("def_c1260_hi", int'(gate_hi), 'b1010);
    chk("def_c1260_lo", int'(gate_lo), 'b0101);
    count_ps(n);
    chk("def_ps_gap", n, 1239);

    // mid-period reconfiguration takes effect at the wrap
    repeat (300) tick();
    do_load(2000, 800, 5, 500);
    wait_ps("wrap_ps");
    count_ps(n);
    chk("new_period_len", n, 2000);

    // validity boundaries
    for (int i = 0; i < 7; i++) begin
      do_load(bad_tab[i][0], bad_tab[i][1], bad_tab[i][2], bad_tab[i][3]);
      @(negedge clk);
      chk($sformatf("cfg_err_%0d", i), int'(cfg_err), bad_tab[i][4]);
    end

    // safety shutdown at cnt 600 and restart
    run_until_cnt(600);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("off_act", int'(active), 0);
    chk("off_hi", int'(gate_hi), 0);
    chk("off_lo", int'(gate_lo), 0);
    tick();
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_ps", int'(period_start), 1);
    chk("restart_act", int'(active), 1);

    // two loads in one period, third on the wrap cycle
    repeat (100) tick();
    do_load(400, 200, 3, 100);
    repeat (100) tick();
    do_load(300, 150, 2, 75);
    run_until_cnt(m_per - 1);
    do_load(200, 100, 1, 50);
    wait_ps("multi_ps");
    count_ps(n);
    chk("second_load_len", n, 300);
    count_ps(n);
    chk("wrap_load_len", n, 200);

    // four legs at phase 625: offsets 0/625/1250/1875
    do_load(2500, 1250, 10, 625);
    wait_ps("ph625_ps");
    repeat (636) @(negedge clk);
    chk("ph625_hi", int'(gate_hi), 'b0011);
    chk("ph625_lo", int'(gate_lo), 'b1100);

    // reset mid-run restores defaults
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", int'(gate_hi), 0);
    chk("rst_lo", int'(gate_lo), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_act", int'(active), 0);
    chk("rst_err", int'(cfg_err), 0);
    wait_ps("post_rst_ps");
    repeat (11) @(negedge clk);
    chk("post_rst_hi", int'(gate_hi), 'b0101);
    chk("post_rst_lo", int'(gate_lo), 'b1010);

    // randomized traffic, short periods
    do_load(20, 10, 2, 5);
    for (int i = 0; i < 6000; i++) begin
      int r, p;
      tick();
      load = 1'b0;
      rst  = 1'b0;
      r = $urandom_range(0, 199);
      if (r < 8) begin
        p = (r == 0) ? $urandom_range(0, 5) : $urandom_range(4, 60);
        cfg_period = 16'(p);
        cfg_on     = 16'($urandom_range(0, p + 1));
        cfg_dead   = 8'($urandom_range(0, p / 2 + 1));
        cfg_phase  = 16'($urandom_range(0, p + 1));
        load = 1'b1;
      end else if (r < 11) begin
        enable = ~enable;
      end else if (r == 11 && $urandom_range(0, 7) == 0) begin
        rst = 1'b1;
      end
    end
    tick();
    load = 1'b0;
    rst  = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
